// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm main module and its status link scheduler.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  localparam logic [1:0] TAG_ALARM  = 2'b01;
  localparam logic [1:0] TAG_KEY    = 2'b10;
  localparam logic [1:0] TAG_STATUS = 2'b11;

  localparam int unsigned MSG_W_DEF = 4;
  localparam int unsigned FRAME_W   = 2 + MSG_W_DEF;

  // Status-message bit positions used by the alarm FSM
  localparam int unsigned STAT_ARMED   = 0;
  localparam int unsigned STAT_ALARM   = 1;
  localparam int unsigned STAT_SENSOR1 = 2;
  localparam int unsigned STAT_SENSOR2 = 3;

endpackage

// File: rtl/req_arbiter.sv
// Combinational grant: source 0 absolute priority, sources 1/2 round-robin.
module req_arbiter (
  input  logic [2:0] i_req,
  input  logic       i_en,
  input  logic       i_rr_ptr,
  output logic [2:0] o_grant_c,
  output logic       o_valid_c
);

  // i_rr_ptr = 0: source 2 loses a 1/2 tie; i_rr_ptr = 1: source 1 loses
  always_comb begin
    o_grant_c = 3'b000;
    if (i_en) begin
      if (i_req[0]) begin
        o_grant_c = 3'b001;
      end else if (i_req[1] && (!i_req[2] || !i_rr_ptr)) begin
        o_grant_c = 3'b010;
      end else if (i_req[2]) begin
        o_grant_c = 3'b100;
      end
    end
  end

  assign o_valid_c = |o_grant_c;

endmodule

// File: rtl/status_tx_scheduler.sv
// Shares the serial status link among alarm, keypad and refresh sources;
// sends one tagged frame {TAG, MSG} MSB first, then a stand-by gap.
module status_tx_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned MSG_W     = 4,
  parameter int unsigned SB_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [2:0]       REQ,
  input  logic [MSG_W-1:0] MSG0,
  input  logic [MSG_W-1:0] MSG1,
  input  logic [MSG_W-1:0] MSG2,
  output logic [2:0]       ACK,
  output logic             BUSY,
  output logic             STATUS_OUT,
  output logic             STATUS_SEND
);

  localparam int unsigned FW       = 2 + MSG_W;
  localparam logic [2:0]  BIT_LOAD = 3'(FW - 1);
  localparam logic [3:0]  GAP_LOAD = 4'((SB_CYCLES == 0) ? 0 : SB_CYCLES - 1);

  tx_state_e     r_state, w_state_nxt;
  logic [FW-1:0] r_shift, w_shift_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic [2:0]    r_ack, w_ack_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_send, w_send_nxt;
  logic          r_rr_ptr, w_rr_ptr_nxt;
  logic [2:0]    w_grant;
  logic          w_valid;
  logic [FW-1:0] w_frame;

  req_arbiter u_arb (
    .i_req     (REQ),
    .i_en      (EN && (r_state == ST_IDLE)),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant_c (w_grant),
    .o_valid_c (w_valid)
  );

  // Frame of the granted source
  always_comb begin
    w_frame = '0;
    if (w_grant[0]) begin
      w_frame = {TAG_ALARM, MSG0};
    end else if (w_grant[1]) begin
      w_frame = {TAG_KEY, MSG1};
    end else if (w_grant[2]) begin
      w_frame = {TAG_STATUS, MSG2};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_ack_nxt     = 3'b000;
    w_busy_nxt    = r_busy;
    w_send_nxt    = 1'b0;
    w_rr_ptr_nxt  = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_valid) begin
          w_state_nxt   = ST_SHIFT;
          w_shift_nxt   = w_frame;
          w_bit_cnt_nxt = BIT_LOAD;
          w_ack_nxt     = w_grant;
          w_busy_nxt    = 1'b1;
          w_send_nxt    = 1'b1;
          if (w_grant[1]) begin
            w_rr_ptr_nxt = 1'b1;
          end else if (w_grant[2]) begin
            w_rr_ptr_nxt = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        w_shift_nxt = {r_shift[FW-2:0], 1'b0};
        if (r_bit_cnt == 3'd0) begin
          if (SB_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = GAP_LOAD;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - 3'd1;
          w_send_nxt    = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= 3'd0;
      r_gap_cnt <= 4'd0;
      r_ack     <= 3'b000;
      r_busy    <= 1'b0;
      r_send    <= 1'b0;
      r_rr_ptr  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
      r_send    <= w_send_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  assign ACK         = r_ack;
  assign BUSY        = r_busy;
  assign STATUS_SEND = r_send;
  assign STATUS_OUT  = r_shift[FW-1];

endmodule

// File: doc/status_tx_scheduler.md
# status_tx_scheduler

Shares the single serial status channel (STATUS_OUT / STATUS_SEND) of the alarm main module among three message sources: alarm events, keypad feedback and periodic status refresh. It arbitrates pending requests, tags the winner with a 2-bit source ID, and serializes one frame at a time. Each frame is followed by a stand-by gap. It sits between the alarm state machine / keypad checker and the physical status link, and replaces the free-running single-source serializer.

## Interface
- `MSG_W`, default 4: payload width per request.
- `SB_CYCLES`, default 3: stand-by cycles after each frame, range 0..15.
- `CLK` in, 1: system clock (the LSOSC-derived serial clock); all logic on the rising edge.
- `RST_N` in, 1: reset, asynchronous, active-low.
- `EN` in, 1: grant enable. When low, no new grants are issued; a frame already in progress completes.
- `REQ` in, 3: per-source request, level, held until its ACK. `REQ[0]` = alarm event, `REQ[1]` = keypad feedback, `REQ[2]` = status refresh.
- `MSG0`, `MSG1`, `MSG2` in, MSG_W each: payloads. Each must be stable while its REQ is high.
- `ACK` out, 3: one-cycle grant pulse per source.
- `BUSY` out, 1: high from the grant edge until the end of the gap.
- `STATUS_OUT` out, 1: serial data, MSB first.
- `STATUS_SEND` out, 1: high during every data bit of a frame.

## Operation
- Frame layout: FRAME_W = 2 + MSG_W bits = {TAG[1:0], MSG}. TAG = source index + 1, giving 01, 10 or 11. TAG 00 never appears on the line.
- States:
  - IDLE: outputs low. If `EN` and any `REQ` bit is set, arbitrate. At that edge, load the shift register with {TAG, MSG} of the winner, set `ACK[winner]` (registered, high during the next cycle), set `BUSY`, and go to SHIFT.
  - SHIFT: `STATUS_SEND` = 1, `STATUS_OUT` = shift register MSB; shift left each cycle. After FRAME_W cycles, go to GAP, or to IDLE if SB_CYCLES = 0.
  - GAP: `STATUS_SEND` = 0 and `STATUS_OUT` = 0 for SB_CYCLES cycles, then go to IDLE and clear `BUSY`.
- Arbitration:
  - `REQ[0]` has absolute priority.
  - Between `REQ[1]` and `REQ[2]`, use round-robin: a 1-bit pointer names the source that loses the next tie. The pointer is updated only when source 1 or 2 is granted.
  - Reset value of the pointer favours source 1.
- Requests are re-sampled only in IDLE.
  - A REQ withdrawn before its grant is simply never served.
  - A REQ still high during the ACK cycle is ignored; the requester must drop it by the next IDLE.
- MSG is captured only at the grant edge. Later changes do not affect the frame in flight.
- `EN` falling during SHIFT or GAP has no effect on the current frame. With `EN` low, the block stays in IDLE with `ACK` = 000.

## Timing
- Reset values: `STATUS_OUT` = 0, `STATUS_SEND` = 0, `ACK` = 000, `BUSY` = 0, state = IDLE, RR pointer favours 1, shift register = 0.
- Reset asserted mid-frame: all outputs go low immediately and asynchronously, and the frame is discarded. After release, the first grant is possible at the first edge.
- Latency, REQ sampled in IDLE at edge t:
  - `ACK` and `BUSY` are high during cycle t+1.
  - The first bit (TAG[1]) is on the line in cycle t+1.
  - The last payload bit is in cycle t+FRAME_W.
- Back-to-back frame period: 1 + FRAME_W + SB_CYCLES cycles, i.e. 10 cycles at the defaults.
- Bit counter: 3 bits, sized for FRAME_W ≤ 8. Gap counter: 4 bits. Neither counter ever wraps; both are reloaded on state entry.
- Simultaneous `REQ` = 111: sources are served in the order 0, then 1/2 per the pointer. Source 0 re-requesting wins every IDLE cycle; starvation of sources 1/2 by source 0 is accepted by design.

## Structure
- Shared package `alarm_pkg` holds:
  - state encoding: IDLE = 0, SHIFT = 1, GAP = 2;
  - TAG constants: TAG_ALARM = 2'b01, TAG_KEY = 2'b10, TAG_STATUS = 2'b11;
  - FRAME_W;
  - the status-message bit positions already used by the alarm FSM (sensor2, sensor1, alarm, armed).
- One sub-module, `req_arbiter`: purely combinational priority plus round-robin grant. Inputs are REQ, EN and the pointer; outputs are a one-hot grant and a valid flag. The pointer register stays in the parent.

## Test plan
- `REQ` = 001, MSG0 = 4'b1010 → ACK = 001 for one cycle; SEND high for 6 cycles; OUT = 0,1,1,0,1,0; then 3 gap cycles with SEND = 0.
- `REQ` = 110 held, MSG1 = 4'h5, MSG2 = 4'hC → frames alternate with tags 10, 11, 10, …, one frame every 10 cycles.
- `REQ` = 111 → first frame has tag 01. Drop `REQ[0]` after its ACK → next frame has tag 10, then 11.
- `EN` = 0 with `REQ` = 010 for 20 cycles → no ACK and SEND stays 0. Raise `EN` → ACK = 010 on the next edge.
- Pulse `RST_N` low at bit 3 of a frame → OUT, SEND and BUSY go low immediately. A pending `REQ[2]` is then served with a full frame starting one cycle after release.
- SB_CYCLES = 0 build, `REQ[0]` held → frames are separated by exactly one idle cycle (7-cycle period).
